// File: rtl/block_config_loader_if.sv
// Bit-serial configuration stream: one data bit per transfer under valid/ready.
// The source drives cfg_bit/cfg_valid; the loader answers with cfg_ready.
interface block_config_loader_if;
  logic cfg_bit;
  logic cfg_valid;
  logic cfg_ready;

  modport master (
    output cfg_bit,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_bit,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/block_config_loader.sv
// Serial loader that assembles MEM_SIZE-bit words from an LSB-first bit stream and
// strobes them one block at a time into NUM_BLOCKS downstream latch blocks.

// Property checker for the loader outputs; instantiated alongside the loader.
module block_config_loader_chk #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [NUM_BLOCKS-1:0] comb_set,
  input logic [MEM_SIZE-1:0]   config_out,
  input logic                  cfg_ready,
  input logic                  busy,
  input logic                  done
);
  localparam logic [NUM_BLOCKS-1:0] SET_NONE = {NUM_BLOCKS{1'b0}};

  a_onehot_set: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(comb_set));

  a_set_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    (comb_set != SET_NONE) |=> (comb_set == SET_NONE));

  a_word_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (comb_set != SET_NONE) |=> $stable(config_out));

  a_set_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (comb_set != SET_NONE) |-> (!cfg_ready && busy));

  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

  a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
    cfg_ready |-> busy);
endmodule

module block_config_loader #(
  parameter  int ADDR_BITS  = 4,
  parameter  int MEM_SIZE   = 2 ** ADDR_BITS,
  parameter  int NUM_BLOCKS = 4,
  localparam int BLK_BITS   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  block_config_loader_if.slave      cfg,
  output logic [MEM_SIZE-1:0]       config_out,
  output logic [NUM_BLOCKS-1:0]     comb_set,
  output logic [BLK_BITS-1:0]       blk_idx,
  output logic                      busy,
  output logic                      done
);
  localparam int CNT_W = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(MEM_SIZE - 1);
  localparam logic [BLK_BITS-1:0]   LAST_BLK = BLK_BITS'(NUM_BLOCKS - 1);
  localparam logic [NUM_BLOCKS-1:0] SET_BASE = NUM_BLOCKS'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [BLK_BITS-1:0]   blk_idx_q,   blk_idx_d;
  logic [MEM_SIZE-1:0]   config_q,    config_d;
  logic [NUM_BLOCKS-1:0] comb_set_q,  comb_set_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  xfer_s;

  // cfg_ready_q mirrors "state is LOAD", so the handshake never looks at the raw state
  assign xfer_s = cfg.cfg_valid & cfg_ready_q;

  // Next-state, shift register, bit counter and block index
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    blk_idx_d = blk_idx_q;
    config_d  = config_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = {CNT_W{1'b0}};
          blk_idx_d = {BLK_BITS{1'b0}};
        end else begin
          state_d   = state_q;
        end
      end
      ST_LOAD: begin
        if (xfer_s) begin
          config_d  = {cfg.cfg_bit, config_q[MEM_SIZE-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_COMMIT: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (blk_idx_q == LAST_BLK) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_LOAD;
          blk_idx_d = blk_idx_q + BLK_BITS'(1);
          bit_cnt_d = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values decoded from the next state so every output leaves a flop
  always_comb begin
    comb_set_d  = {NUM_BLOCKS{1'b0}};
    cfg_ready_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_LOAD: begin
        cfg_ready_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_COMMIT: begin
        comb_set_d  = SET_BASE << blk_idx_d;
        busy_d      = 1'b1;
      end
      ST_HOLD: begin
        busy_d      = 1'b1;
      end
      ST_DONE: begin
        done_d      = 1'b1;
      end
      default: begin
        comb_set_d  = {NUM_BLOCKS{1'b0}};
      end
    endcase
  end

  // State and output registers; reset clears the set strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= {CNT_W{1'b0}};
      blk_idx_q   <= {BLK_BITS{1'b0}};
      config_q    <= {MEM_SIZE{1'b0}};
      comb_set_q  <= {NUM_BLOCKS{1'b0}};
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      blk_idx_q   <= blk_idx_d;
      config_q    <= config_d;
      comb_set_q  <= comb_set_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign config_out    = config_q;
  assign comb_set      = comb_set_q;
  assign blk_idx       = blk_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_block_config_loader.sv
// Directed bench for block_config_loader: table-driven full-rate sessions plus
// hand-written stall, ready-gating, start-handling and reset sequences.
module tb_block_config_loader;
  localparam int MS = 16;
  localparam int NB = 4;
  localparam int PER_BLK = MS + 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [MS-1:0] config_out;
  logic [NB-1:0] comb_set;
  logic [1:0]    blk_idx;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  block_config_loader_if cif ();

  block_config_loader #(.ADDR_BITS(4), .MEM_SIZE(MS), .NUM_BLOCKS(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg        (cif.slave),
    .config_out (config_out),
    .comb_set   (comb_set),
    .blk_idx    (blk_idx),
    .busy       (busy),
    .done       (done)
  );

  block_config_loader_chk #(.MEM_SIZE(MS), .NUM_BLOCKS(NB)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .comb_set   (comb_set),
    .config_out (config_out),
    .cfg_ready  (cif.cfg_ready),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cycle: 1-based cycle number after the start edge in which comb_set is high
  typedef struct {
    logic [15:0] word;
    logic [3:0]  set;
    int          cycle;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full-rate session over four table entries; COMMIT/HOLD cycles carry garbage with valid=1
  task automatic run_session(input int base);
    logic [3:0]  exp_set;
    logic [15:0] w;
    int k;
    int p;
    start = 1'b1;
    cif.cfg_valid = 1'b0;
    tick();
    start = 1'b0;
    check("start_done_low", 32'(done), 32'd0);
    check("start_blk_idx", 32'(blk_idx), 32'd0);
    check("start_ready", 32'(cif.cfg_ready), 32'd1);
    for (int n = 1; n <= NB * PER_BLK; n++) begin
      k = (n - 1) / PER_BLK;
      p = (n - 1) % PER_BLK;
      w = tbl[base + k].word;
      cif.cfg_valid = 1'b1;
      cif.cfg_bit   = (p < MS) ? w[p] : 1'($urandom);
      tick();
      exp_set = 4'b0000;
      for (int v = 0; v < NB; v++) begin
        if (n == tbl[base + v].cycle - 1) exp_set = tbl[base + v].set;
      end
      check("comb_set", 32'(comb_set), 32'(exp_set));
      if (p >= MS - 1) check("config_out_word", 32'(config_out), 32'(w));
      if (p == MS - 1) check("blk_idx_commit", 32'(blk_idx), 32'(k));
      check("done", 32'(done), 32'(n == NB * PER_BLK));
      check("busy", 32'(busy), 32'(n < NB * PER_BLK));
      check("cfg_ready", 32'(cif.cfg_ready),
            32'((p < MS - 1) || (p == PER_BLK - 1 && k < NB - 1)));
    end
    cif.cfg_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] sw;
    int i;
    int n;
    int stalls;
    logic v;

    tbl[0] = '{16'hA5C3, 4'b0001, 17};
    tbl[1] = '{16'h0001, 4'b0010, 35};
    tbl[2] = '{16'h8000, 4'b0100, 53};
    tbl[3] = '{16'hFFFF, 4'b1000, 71};
    tbl[4] = '{16'h0F0F, 4'b0001, 17};
    tbl[5] = '{16'h3C3C, 4'b0010, 35};
    tbl[6] = '{16'h0000, 4'b0100, 53};
    tbl[7] = '{16'h7FFE, 4'b1000, 71};

    rst_n = 1'b1;
    start = 1'b0;
    cif.cfg_valid = 1'b0;
    cif.cfg_bit   = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_config_out", 32'(config_out), 32'd0);
    check("rst_comb_set", 32'(comb_set), 32'd0);
    check("rst_blk_idx", 32'(blk_idx), 32'd0);
    check("rst_ready", 32'(cif.cfg_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // IDLE gating: valid bits must not shift in
    for (int c = 0; c < 4; c++) begin
      cif.cfg_valid = 1'b1;
      cif.cfg_bit   = 1'b1;
      tick();
      check("idle_no_shift", 32'(config_out), 32'd0);
      check("idle_ready", 32'(cif.cfg_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
    cif.cfg_valid = 1'b0;

    run_session(0);

    // DONE gating: last word must survive garbage valid bits
    for (int c = 0; c < 4; c++) begin
      cif.cfg_valid = 1'b1;
      cif.cfg_bit   = 1'($urandom);
      tick();
      check("done_no_shift", 32'(config_out), 32'hFFFF);
      check("done_held", 32'(done), 32'd1);
    end
    cif.cfg_valid = 1'b0;

    run_session(4);

    // Stalled stream of 0x1234: comb_set only after the 16th accepted bit
    sw = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    n = 0;
    stalls = 0;
    while (i < MS && n < 200) begin
      v = (n == 0 || n == 5) ? 1'b0 : 1'($urandom_range(0, 1));
      cif.cfg_valid = v;
      cif.cfg_bit   = v ? sw[i] : 1'($urandom);
      tick();
      n++;
      if (v) i++;
      else stalls++;
      if (i < MS) begin
        check("stall_no_set", 32'(comb_set), 32'd0);
        check("stall_ready", 32'(cif.cfg_ready), 32'd1);
      end
    end
    check("stall_xfer_count", 32'(i), 32'd16);
    check("stall_commit_set", 32'(comb_set), 32'b0001);
    check("stall_commit_word", 32'(config_out), 32'h1234);
    cif.cfg_valid = 1'b1;
    cif.cfg_bit   = 1'b1;
    tick();
    check("hold_no_set", 32'(comb_set), 32'd0);
    check("hold_word", 32'(config_out), 32'h1234);
    check("hold_ready", 32'(cif.cfg_ready), 32'd0);
    tick();
    check("load1_blk_idx", 32'(blk_idx), 32'd1);
    check("load1_word_kept", 32'(config_out), 32'h1234);

    // start during LOAD is ignored; three 1-bits shift in
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("load_start_blk_idx", 32'(blk_idx), 32'd1);
      check("load_start_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    cif.cfg_valid = 1'b0;
    check("partial_word", 32'(config_out), 32'hE246);

    // Asynchronous reset mid-LOAD
    #2 rst_n = 1'b0;
    #1;
    check("midrst_config_out", 32'(config_out), 32'd0);
    check("midrst_comb_set", 32'(comb_set), 32'd0);
    check("midrst_ready", 32'(cif.cfg_ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_blk_idx", 32'(blk_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    cif.cfg_valid = 1'b1;
    tick();
    check("postrst_idle_ready", 32'(cif.cfg_ready), 32'd0);
    check("postrst_idle_busy", 32'(busy), 32'd0);
    check("postrst_idle_done", 32'(done), 32'd0);
    check("postrst_no_shift", 32'(config_out), 32'd0);
    cif.cfg_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/block_config_loader.md
# block_config_loader

Serial configuration loader that sits directly upstream of the SLICEL configuration latch blocks. It accepts a bit-serial configuration stream under a valid/ready handshake and assembles each MEM_SIZE-bit word. It then drives the shared config word plus a one-hot set strobe, so each of NUM_BLOCKS latch blocks captures its word in turn. Once all blocks are written it signals completion.

## Interface

- ADDR_BITS, 4, LUT address width of each downstream latch block
- MEM_SIZE, 2**ADDR_BITS, bits per latch block word
- NUM_BLOCKS, 4, number of latch blocks loaded per session (≥1); BLK_BITS = max(1, clog2(NUM_BLOCKS))
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a load session; sampled only in IDLE and DONE
- cfg_bit  input  1  serial configuration data bit
- cfg_valid  input  1  cfg_bit is valid this cycle
- cfg_ready  output  1  loader accepts a bit this cycle; transfer = cfg_valid & cfg_ready
- config_out  output  MEM_SIZE  shared config word to all latch blocks' config_in
- comb_set  output  NUM_BLOCKS  one-hot set strobe; bit i drives block i's comb_set
- blk_idx  output  BLK_BITS  index of the block currently being loaded
- busy  output  1  high in LOAD, COMMIT, HOLD
- done  output  1  high in DONE

## Operation

- Reset (rst_n low, immediate): state=IDLE; config_out=0, comb_set=0, blk_idx=0, bit count=0, cfg_ready=0, busy=0, done=0.
- Shift rule: on each transfer, config_out <= {cfg_bit, config_out[MEM_SIZE-1:1]}. The first bit of a word lands in config_out[0] after MEM_SIZE transfers (LSB-first stream). Bit counter width is ADDR_BITS+1 and must not wrap mid-word.
- States:
  - IDLE: cfg_ready=0. start=1 -> LOAD with bit count=0 and blk_idx=0.
  - LOAD: cfg_ready=1. Each transfer increments bit count. The transfer of bit MEM_SIZE-1 -> COMMIT. cfg_valid=0 stalls the loader with no state change.
  - COMMIT: cfg_ready=0; comb_set = 1<<blk_idx for exactly this one cycle; config_out frozen. -> HOLD.
  - HOLD: comb_set=0; config_out frozen (hold time for level-sensitive latches). If blk_idx==NUM_BLOCKS-1 -> DONE; else blk_idx++, bit count=0 -> LOAD.
  - DONE: done=1, cfg_ready=0, config_out keeps the last word. start=1 -> LOAD with blk_idx=0 and bit count=0; done drops the same edge.
- start is ignored in LOAD/COMMIT/HOLD. No abort except rst_n.
- config_out holds a partial word during LOAD. It is meaningful only while comb_set is nonzero and in the HOLD cycle after it.
- At most one comb_set bit is ever high; comb_set is all-zero outside COMMIT.
- cfg_bit is ignored whenever cfg_ready=0, even if cfg_valid=1.

## Timing

- All outputs are registered; no combinational path from inputs to outputs except none (cfg_ready is a state decode).
- Full-rate stream (cfg_valid held high): the start edge enters LOAD. Block k's comb_set is high in cycle 1 + k*(MEM_SIZE+2) + MEM_SIZE after that edge (k from 0).
- Per block: MEM_SIZE transfer cycles + 1 COMMIT + 1 HOLD = MEM_SIZE+2 cycles minimum.
- done rises NUM_BLOCKS*(MEM_SIZE+2) cycles after the start edge at full rate. Stalls add 1 cycle each.
- config_out is stable from the edge entering COMMIT until the edge leaving HOLD (2 cycles). comb_set falls one cycle before config_out may change.
- Reset mid-operation forces comb_set to 0 asynchronously. Latch contents already written are not the loader's concern; the session must be restarted.

## Test plan

- Reset values: assert rst_n=0 mid-LOAD -> immediately comb_set=0, config_out=0, cfg_ready=0, busy=0, done=0; after release, state is IDLE.
- Full-rate load (MEM_SIZE=16, NUM_BLOCKS=4): stream words 0xA5C3, 0x0001, 0x8000, 0xFFFF LSB-first with cfg_valid high. Required: comb_set=0001, 0010, 0100, 1000 at cycles 17, 35, 53, 71 after start; config_out equals the matching word on each; done at cycle 72.
- Stalls: toggle cfg_valid randomly while loading word 0x1234 -> config_out=0x1234 at COMMIT; exactly 16 transfers counted; comb_set timing shifts by the stall count.
- Ready gating: drive cfg_valid=1 with garbage bits during IDLE, COMMIT, HOLD, DONE -> no shift; config_out unchanged across those cycles.
- start handling: pulse start during LOAD -> ignored, blk_idx unchanged. Pulse start in DONE -> done=0 and blk_idx=0 next cycle; a new session loads 4 blocks correctly.
- One-hot check: across a full session, assert popcount(comb_set)≤1 every cycle and config_out stable whenever comb_set≠0 and for one cycle after.
